// File: rtl/dev_bus_arbiter_pkg.sv
// Shared types for the device-bus arbiter slice.
//   arb_state_t : arbiter FSM state (IDLE, BUSY0, BUSY1)
//   dbus_req_t  : requester-to-device half of the bus handshake
//   dbus_resp_t : device-to-requester half of the bus handshake
//   TIMEOUT_W   : width of the optional watchdog counter
package dev_arb_pkg;

  localparam int TIMEOUT_W = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic        wvalid;
    logic [7:0]  size;
    logic [63:0] wdata;
  } dbus_req_t;

  typedef struct packed {
    logic [63:0] rdata;
    logic        ready;
    logic        last;
  } dbus_resp_t;

endpackage

// File: rtl/dev_bus_arbiter_if.sv
// Device/MMIO bus handshake bundle.
//   master : side that issues requests (valid, addr, wvalid, size, wdata)
//            and receives responses (rdata, ready, last)
//   slave  : side that accepts requests and returns responses
interface dev_bus_arbiter_if;
  import dev_arb_pkg::*;

  logic        valid;
  logic [63:0] addr;
  logic        wvalid;
  logic [7:0]  size;
  logic [63:0] wdata;
  logic [63:0] rdata;
  logic        ready;
  logic        last;

  modport master (
    output valid, addr, wvalid, size, wdata,
    input  rdata, ready, last
  );

  modport slave (
    input  valid, addr, wvalid, size, wdata,
    output rdata, ready, last
  );

endinterface

// File: rtl/dev_bus_arbiter_watchdog.sv
// Stall watchdog for the device-bus arbiter.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   clear_i    : zero the count (takes precedence over enable_i)
//   enable_i   : count this cycle as a stalled cycle
//   expire_o   : high during the LIMIT-th consecutive enabled cycle
module dev_arb_watchdog
  import dev_arb_pkg::*;
#(
  parameter logic [TIMEOUT_W-1:0] LIMIT = 20'd1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The first stalled cycle sees cnt_q = 0, so the LIMIT-th sees LIMIT-1.
  assign expire_o = enable_i && (cnt_q == LIMIT - 1'b1);

endmodule

// File: rtl/dev_bus_arbiter.sv
// Two-requester round-robin arbiter for the device/MMIO bus.
// The owner keeps the bus until the device returns ready && last; on
// completion the priority pointer flips to the other requester, and if that
// requester is already waiting it is granted with no idle cycle in between.
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   m0, m1      : requester ports (m0 = CPU data port, m1 = debug streamer)
//   dev         : port toward the device block
//   grant_id    : current owner, meaningful only while dev.valid = 1
//   timeout_err : sticky watchdog flag (present only with DEV_ARB_TIMEOUT_EN)
// Optional feature macro: DEV_ARB_TIMEOUT_EN adds a stall watchdog that
// completes a hung transaction itself with all-ones read data.
module dev_bus_arbiter
  import dev_arb_pkg::*;
#(
  parameter int                   NUM_REQ        = 2,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 20'd1000000
) (
  input  logic               clk,
  input  logic               reset,
  dev_bus_arbiter_if.slave   m0,
  dev_bus_arbiter_if.slave   m1,
  dev_bus_arbiter_if.master  dev,
  output logic               grant_id
`ifdef DEV_ARB_TIMEOUT_EN
  ,
  output logic               timeout_err
`endif
);

  if (NUM_REQ != 2) begin : g_bad_num_req
    $error("dev_bus_arbiter supports exactly two requesters");
  end
  if (TIMEOUT_CYCLES == '0) begin : g_bad_timeout
    $error("dev_bus_arbiter TIMEOUT_CYCLES must be nonzero");
  end

  arb_state_t state_q, state_d;
  logic       prio_q, prio_d;
  dbus_req_t  req0, req1, dev_req;
  dbus_resp_t dev_resp, resp0, resp1;
  logic       wd_fire;

  assign req0 = '{valid: m0.valid, addr: m0.addr, wvalid: m0.wvalid,
                  size: m0.size, wdata: m0.wdata};
  assign req1 = '{valid: m1.valid, addr: m1.addr, wvalid: m1.wvalid,
                  size: m1.size, wdata: m1.wdata};
  assign dev_resp = '{rdata: dev.rdata, ready: dev.ready, last: dev.last};

`ifdef DEV_ARB_TIMEOUT_EN
  logic busy;
  logic wd_expire;
  logic timeout_err_q;

  assign busy = (state_q == BUSY0) || (state_q == BUSY1);

  dev_arb_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (!busy || dev.ready),
    .enable_i (busy && !dev.ready),
    .expire_o (wd_expire)
  );

  // An abort in the same cycle wins over the watchdog.
  assign wd_fire = wd_expire && !reset &&
                   (((state_q == BUSY0) && m0.valid) ||
                    ((state_q == BUSY1) && m1.valid));

  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_err_q <= 1'b0;
    end else if (wd_fire) begin
      timeout_err_q <= 1'b1;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign wd_fire = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    dev_req  = '0;
    resp0    = '0;
    resp1    = '0;
    grant_id = 1'b0;
    // Outputs are held quiet while reset is asserted so a transaction that
    // was in flight is dropped immediately, not one cycle later.
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (m0.valid && (!m1.valid || !prio_q)) begin
            state_d = BUSY0;
          end else if (m1.valid) begin
            state_d = BUSY1;
          end
        end
        BUSY0: begin
          dev_req = req0;
          resp0   = dev_resp;
          if (!m0.valid) begin
            state_d = IDLE;
          end else if (wd_fire) begin
            dev_req.valid = 1'b0;
            resp0   = '{rdata: {64{1'b1}}, ready: 1'b1, last: 1'b1};
            prio_d  = 1'b1;
            state_d = IDLE;
          end else if (dev.ready && dev.last) begin
            prio_d  = 1'b1;
            state_d = m1.valid ? BUSY1 : IDLE;
          end
        end
        BUSY1: begin
          grant_id = 1'b1;
          dev_req  = req1;
          resp1    = dev_resp;
          if (!m1.valid) begin
            state_d = IDLE;
          end else if (wd_fire) begin
            dev_req.valid = 1'b0;
            resp1   = '{rdata: {64{1'b1}}, ready: 1'b1, last: 1'b1};
            prio_d  = 1'b0;
            state_d = IDLE;
          end else if (dev.ready && dev.last) begin
            prio_d  = 1'b0;
            state_d = m0.valid ? BUSY0 : IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
    end
  end

  assign dev.valid  = dev_req.valid;
  assign dev.addr   = dev_req.addr;
  assign dev.wvalid = dev_req.wvalid;
  assign dev.size   = dev_req.size;
  assign dev.wdata  = dev_req.wdata;

  assign m0.rdata = resp0.rdata;
  assign m0.ready = resp0.ready;
  assign m0.last  = resp0.last;
  assign m1.rdata = resp1.rdata;
  assign m1.ready = resp1.ready;
  assign m1.last  = resp1.last;

endmodule

// File: tb/tb_dev_bus_arbiter.sv
// Directed self-checking bench for dev_bus_arbiter.
// Build with DEV_ARB_TIMEOUT_EN defined to also exercise the watchdog.
module tb_dev_bus_arbiter;

  localparam logic [63:0] TX_DATA_ADDR = 64'h0000_0000_1000_0000;
  localparam logic [63:0] COUNTER_ADDR = 64'h0000_0000_1000_0010;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic grant_id;
`ifdef DEV_ARB_TIMEOUT_EN
  logic timeout_err;
`endif

  int passed = 0;
  int total  = 0;

  dev_bus_arbiter_if m0_if ();
  dev_bus_arbiter_if m1_if ();
  dev_bus_arbiter_if dev_if ();

  dev_bus_arbiter #(
    .NUM_REQ        (2),
    .TIMEOUT_CYCLES (20'd16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .m0       (m0_if),
    .m1       (m1_if),
    .dev      (dev_if),
    .grant_id (grant_id)
`ifdef DEV_ARB_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_if.valid = 1'b0; m0_if.addr = '0; m0_if.wvalid = 1'b0; m0_if.size = '0; m0_if.wdata = '0;
    m1_if.valid = 1'b0; m1_if.addr = '0; m1_if.wvalid = 1'b0; m1_if.size = '0; m1_if.wdata = '0;
    dev_if.rdata = '0; dev_if.ready = 1'b0; dev_if.last = 1'b0;
  endtask

  // Leaves the bench at the first post-reset cycle (arbiter IDLE, prio 0).
  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    m0_if.valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      #1;
      total++; if (dev_if.valid !== 1'b0) $display("FAIL reset_valid[%0d]: got %b want 0", i, dev_if.valid); else passed++;
      total++; if ({m0_if.ready, m0_if.last, m1_if.ready, m1_if.last} !== 4'b0)
        $display("FAIL reset_resp[%0d]: got %b want 0000", i, {m0_if.ready, m0_if.last, m1_if.ready, m1_if.last}); else passed++;
    end
    next_cycle();
    reset = 1'b0;
    #1;
    total++; if (dev_if.valid !== 1'b0) $display("FAIL reset_first_idle: valid got %b want 0", dev_if.valid); else passed++;
`ifdef DEV_ARB_TIMEOUT_EN
    total++; if (timeout_err !== 1'b0) $display("FAIL reset_timeout_err: got %b want 0", timeout_err); else passed++;
`endif
    next_cycle();
    #1;
    total++; if ({dev_if.valid, grant_id} !== 2'b10) $display("FAIL reset_then_busy0: {valid,grant} got %b want 10", {dev_if.valid, grant_id}); else passed++;
    // Reset arriving mid-transaction drops the request immediately.
    reset = 1'b1;
    #1;
    total++; if (dev_if.valid !== 1'b0) $display("FAIL midreset_valid: got %b want 0", dev_if.valid); else passed++;
    next_cycle();
    reset = 1'b0;
    #1;
    total++; if (dev_if.valid !== 1'b0) $display("FAIL midreset_idle: got %b want 0", dev_if.valid); else passed++;
  endtask

  task automatic test_single_write();
    do_reset();
    m0_if.valid = 1'b1; m0_if.wvalid = 1'b1; m0_if.addr = TX_DATA_ADDR;
    m0_if.size = 8'd8; m0_if.wdata = 64'h0000_0048_0000_0000;
    #1;
    total++; if (dev_if.valid !== 1'b0) $display("FAIL wr_idle_valid: got %b want 0", dev_if.valid); else passed++;
    next_cycle();
    #1;
    total++; if (dev_if.valid !== 1'b1) $display("FAIL wr_busy_valid: got %b want 1", dev_if.valid); else passed++;
    total++; if (dev_if.addr !== TX_DATA_ADDR) $display("FAIL wr_addr: got %h want %h", dev_if.addr, TX_DATA_ADDR); else passed++;
    total++; if (dev_if.wdata !== 64'h0000_0048_0000_0000) $display("FAIL wr_wdata: got %h want 0000004800000000", dev_if.wdata); else passed++;
    total++; if ({dev_if.wvalid, dev_if.size} !== {1'b1, 8'd8}) $display("FAIL wr_ctl: got %b/%0d want 1/8", dev_if.wvalid, dev_if.size); else passed++;
    total++; if (m0_if.ready !== 1'b0) $display("FAIL wr_early_ready: got %b want 0", m0_if.ready); else passed++;
    next_cycle();
    dev_if.ready = 1'b1; dev_if.last = 1'b1;
    #1;
    total++; if ({m0_if.ready, m0_if.last} !== 2'b11) $display("FAIL wr_done: {ready,last} got %b want 11", {m0_if.ready, m0_if.last}); else passed++;
    total++; if ({m1_if.ready, m1_if.last} !== 2'b00) $display("FAIL wr_m1_quiet: got %b want 00", {m1_if.ready, m1_if.last}); else passed++;
    next_cycle();
    m0_if.valid = 1'b0; dev_if.ready = 1'b0; dev_if.last = 1'b0;
    #1;
    total++; if ({m0_if.ready, dev_if.valid} !== 2'b00) $display("FAIL wr_after: {ready,valid} got %b want 00", {m0_if.ready, dev_if.valid}); else passed++;
    // prio is now 1: a contended request must go to m1.
    m0_if.valid = 1'b1; m0_if.wvalid = 1'b0;
    m1_if.valid = 1'b1;
    next_cycle();
    #1;
    total++; if ({dev_if.valid, grant_id} !== 2'b11) $display("FAIL wr_prio_flip: {valid,grant} got %b want 11", {dev_if.valid, grant_id}); else passed++;
  endtask

  task automatic test_contended_read();
    do_reset();
    m0_if.valid = 1'b1; m0_if.addr = COUNTER_ADDR; m0_if.size = 8'd8;
    m1_if.valid = 1'b1; m1_if.addr = COUNTER_ADDR; m1_if.size = 8'd8;
    dev_if.rdata = 64'd7;
    next_cycle();
    dev_if.ready = 1'b1; dev_if.last = 1'b1;
    #1;
    total++; if (grant_id !== 1'b0) $display("FAIL rd_first_grant: got %b want 0", grant_id); else passed++;
    total++; if ({m0_if.ready, m0_if.rdata} !== {1'b1, 64'd7}) $display("FAIL rd_m0_data: got %b/%0d want 1/7", m0_if.ready, m0_if.rdata); else passed++;
    total++; if ({m1_if.ready, m1_if.rdata} !== {1'b0, 64'd0}) $display("FAIL rd_m1_blocked: got %b/%0d want 0/0", m1_if.ready, m1_if.rdata); else passed++;
    next_cycle();
    m0_if.valid = 1'b0;
    #1;
    total++; if ({dev_if.valid, grant_id} !== 2'b11) $display("FAIL rd_handover: {valid,grant} got %b want 11", {dev_if.valid, grant_id}); else passed++;
    total++; if ({m1_if.ready, m1_if.rdata} !== {1'b1, 64'd7}) $display("FAIL rd_m1_data: got %b/%0d want 1/7", m1_if.ready, m1_if.rdata); else passed++;
    total++; if (m0_if.ready !== 1'b0) $display("FAIL rd_m0_quiet: got %b want 0", m0_if.ready); else passed++;
    next_cycle();
    m0_if.valid = 1'b1;
    dev_if.ready = 1'b0; dev_if.last = 1'b0;
    #1;
    total++; if (dev_if.valid !== 1'b0) $display("FAIL rd_idle_between: got %b want 0", dev_if.valid); else passed++;
    next_cycle();
    #1;
    total++; if ({dev_if.valid, grant_id} !== 2'b10) $display("FAIL rd_second_round: {valid,grant} got %b want 10", {dev_if.valid, grant_id}); else passed++;
  endtask

  task automatic test_burst();
    do_reset();
    m1_if.valid = 1'b1; m1_if.addr = COUNTER_ADDR; m1_if.size = 8'd8;
    next_cycle();
    for (int b = 1; b <= 4; b++) begin
      dev_if.ready = 1'b1;
      dev_if.last  = (b == 4);
      dev_if.rdata = 64'(b);
      if (b == 2) m0_if.valid = 1'b1;
      #1;
      total++; if (grant_id !== 1'b1) $display("FAIL burst_grant[%0d]: got %b want 1", b, grant_id); else passed++;
      total++; if ({m1_if.ready, m1_if.last} !== {1'b1, (b == 4)})
        $display("FAIL burst_resp[%0d]: {ready,last} got %b want %b", b, {m1_if.ready, m1_if.last}, {1'b1, (b == 4)}); else passed++;
      total++; if (m1_if.rdata !== 64'(b)) $display("FAIL burst_rdata[%0d]: got %0d want %0d", b, m1_if.rdata, b); else passed++;
      total++; if (m0_if.ready !== 1'b0) $display("FAIL burst_m0_quiet[%0d]: got %b want 0", b, m0_if.ready); else passed++;
      next_cycle();
    end
    m1_if.valid = 1'b0; dev_if.ready = 1'b0; dev_if.last = 1'b0;
    #1;
    total++; if ({dev_if.valid, grant_id} !== 2'b10) $display("FAIL burst_then_m0: {valid,grant} got %b want 10", {dev_if.valid, grant_id}); else passed++;
  endtask

  task automatic test_abort();
    do_reset();
    m0_if.valid = 1'b1; m0_if.addr = COUNTER_ADDR;
    next_cycle();
    #1;
    total++; if (dev_if.valid !== 1'b1) $display("FAIL abort_busy: got %b want 1", dev_if.valid); else passed++;
    next_cycle();
    m0_if.valid = 1'b0;
    #1;
    total++; if (dev_if.valid !== 1'b0) $display("FAIL abort_same_cycle: got %b want 0", dev_if.valid); else passed++;
    next_cycle();
    m0_if.valid = 1'b1; m1_if.valid = 1'b1;
    #1;
    total++; if (dev_if.valid !== 1'b0) $display("FAIL abort_idle: got %b want 0", dev_if.valid); else passed++;
    next_cycle();
    #1;
    total++; if ({dev_if.valid, grant_id} !== 2'b10) $display("FAIL abort_prio_kept: {valid,grant} got %b want 10", {dev_if.valid, grant_id}); else passed++;
  endtask

`ifdef DEV_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    m0_if.valid = 1'b1; m0_if.addr = COUNTER_ADDR;
    next_cycle();
    for (int c = 1; c <= 16; c++) begin
      #1;
      if (c < 16) begin
        if (m0_if.ready !== 1'b0 || dev_if.valid !== 1'b1) begin
          total++;
          $display("FAIL to_wait[%0d]: {ready,valid} got %b want 01", c, {m0_if.ready, dev_if.valid});
        end
      end else begin
        total++; if ({m0_if.ready, m0_if.last, dev_if.valid} !== 3'b110)
          $display("FAIL to_fire: {ready,last,valid} got %b want 110", {m0_if.ready, m0_if.last, dev_if.valid}); else passed++;
        total++; if (m0_if.rdata !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL to_rdata: got %h want ffffffffffffffff", m0_if.rdata); else passed++;
      end
      next_cycle();
    end
    m0_if.valid = 1'b0; m1_if.valid = 1'b1;
    #1;
    total++; if ({timeout_err, dev_if.valid} !== 2'b10) $display("FAIL to_err_idle: {err,valid} got %b want 10", {timeout_err, dev_if.valid}); else passed++;
    next_cycle();
    #1;
    total++; if ({dev_if.valid, grant_id, timeout_err} !== 3'b111)
      $display("FAIL to_m1_granted: {valid,grant,err} got %b want 111", {dev_if.valid, grant_id, timeout_err}); else passed++;
  endtask
`endif

  initial begin
    clear_inputs();
    test_reset();
    test_single_write();
    test_contended_read();
    test_burst();
    test_abort();
`ifdef DEV_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL sim_time_limit: bench did not finish within 100000 time units");
    $fatal(1, "time limit");
  end

endmodule
